// File: rtl/fixed_to_fir_pipe.sv
// fixed_to_fir_pipe: two-stage valid/ready pipeline that converts Fx<FX_M,FX_B> fixed point
// into the FIR triple {sign, te, frac}, plus a zero flag and a sticky bit for later rounding.
module fixed_to_fir_pipe #(
  parameter int FX_B          = 16,
  parameter int FX_M          = 8,
  parameter int FIR_TE_SIZE   = 6,
  parameter int FIR_FRAC_SIZE = 8,
  parameter int SIGNED        = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [FX_B-1:0]                        fixed_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [FIR_TE_SIZE+FIR_FRAC_SIZE:0]     fir_o,
  output logic                                   zero_o,
  output logic                                   sticky_o
);

  localparam int LZ_W  = $clog2(FX_B + 1);
  localparam int EXT_W = FX_B + FIR_FRAC_SIZE;

  if ((FX_M - 1) > (2 ** (FIR_TE_SIZE - 1) - 1) ||
      (FX_B - FX_M) > (2 ** (FIR_TE_SIZE - 1))) begin : g_teRangeCheck
    $error("fixed_to_fir_pipe: FIR_TE_SIZE cannot hold the exponent range of Fx<FX_M,FX_B>");
  end

  function automatic logic [LZ_W-1:0] countLz(input logic [FX_B-1:0] value);
    logic found;
    countLz = LZ_W'(FX_B);
    found   = 1'b0;
    for (int i = FX_B - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        countLz = LZ_W'(FX_B - 1 - i);
        found   = 1'b1;
      end
    end
  endfunction

  logic                     w_adv;
  logic                     w_inSign;
  logic [FX_B-1:0]          w_inMag;

  logic                     r_s1Valid;
  logic                     r_s1Sign;
  logic                     r_s1Zero;
  logic [FX_B-1:0]          r_s1Mag;

  logic [LZ_W-1:0]          w_lz;
  logic [FX_B-1:0]          w_norm;
  logic [EXT_W-1:0]         w_ext;
  logic [FIR_FRAC_SIZE-1:0] w_frac;
  logic [FIR_TE_SIZE-1:0]   w_te;
  logic                     w_sticky;

  logic                     r_s2Valid;
  logic                     r_s2Sign;
  logic                     r_s2Zero;
  logic                     r_s2Sticky;
  logic [FIR_TE_SIZE-1:0]   r_s2Te;
  logic [FIR_FRAC_SIZE-1:0] r_s2Frac;

  // Both stages move together; a full output register that is not being taken freezes everything.
  assign w_adv      = !r_s2Valid || out_ready_i;
  assign in_ready_o = w_adv;

  assign w_inSign = (SIGNED != 0) && fixed_i[FX_B-1];
  assign w_inMag  = w_inSign ? (-fixed_i) : fixed_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1Valid <= 1'b0;
      r_s1Sign  <= 1'b0;
      r_s1Zero  <= 1'b0;
      r_s1Mag   <= '0;
    end else if (w_adv) begin
      r_s1Valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1Sign <= w_inSign;
        r_s1Zero <= (fixed_i == '0);
        r_s1Mag  <= w_inMag;
      end
    end
  end

  // Padding norm with FIR_FRAC_SIZE zeros covers both FX_B >= and < FIR_FRAC_SIZE in one slice.
  assign w_lz     = countLz(r_s1Mag);
  assign w_norm   = r_s1Mag << w_lz;
  assign w_ext    = {w_norm, {FIR_FRAC_SIZE{1'b0}}};
  assign w_frac   = w_ext[EXT_W-1 -: FIR_FRAC_SIZE];
  assign w_sticky = |w_ext[FX_B-1:0];
  assign w_te     = FIR_TE_SIZE'(FX_M - 1) - FIR_TE_SIZE'(w_lz);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s2Valid  <= 1'b0;
      r_s2Sign   <= 1'b0;
      r_s2Zero   <= 1'b0;
      r_s2Sticky <= 1'b0;
      r_s2Te     <= '0;
      r_s2Frac   <= '0;
    end else if (w_adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        if (r_s1Zero) begin
          r_s2Sign   <= 1'b0;
          r_s2Zero   <= 1'b1;
          r_s2Sticky <= 1'b0;
          r_s2Te     <= '0;
          r_s2Frac   <= '0;
        end else begin
          r_s2Sign   <= r_s1Sign;
          r_s2Zero   <= 1'b0;
          r_s2Sticky <= w_sticky;
          r_s2Te     <= w_te;
          r_s2Frac   <= w_frac;
        end
      end
    end
  end

  assign out_valid_o = r_s2Valid;
  assign fir_o       = {r_s2Sign, r_s2Te, r_s2Frac};
  assign zero_o      = r_s2Zero;
  assign sticky_o    = r_s2Sticky;

  aHiddenBit: assert property (@(posedge clk_i) disable iff (!rst_i)
    (out_valid_o && !zero_o) |-> fir_o[FIR_FRAC_SIZE-1]);

  aStallStable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(fir_o) && $stable(zero_o) && $stable(sticky_o)));

endmodule
